// File: rtl/data_ram_pkg.sv
// Shared definitions for the data memory: load funct3 encodings, reset/idle
// constants, default depth and the byte-lane word type.
package data_ram_pkg;

   localparam int DATA_RAM_DEPTH = 4096;

   localparam logic [2:0] INST_LB  = 3'b000;
   localparam logic [2:0] INST_LH  = 3'b001;
   localparam logic [2:0] INST_LW  = 3'b010;
   localparam logic [2:0] INST_LBU = 3'b100;
   localparam logic [2:0] INST_LHU = 3'b101;

   localparam logic [31:0] RST_DATA       = 32'h0000_0000;
   localparam logic [3:0]  RAM_WR_DISABLE = 4'b0000;

   // One 32-bit word viewed as four byte lanes; lane n is bits [8n+7:8n].
   typedef logic [3:0][7:0] word_t;

endpackage

// File: rtl/data_ram_if.sv
// Load/store bus between decode/execute and the data memory.
// master drives stores and load requests, slave returns load results.
interface data_ram_if;

   logic [31:0] ram_wr_addr_i;
   logic [31:0] ram_wr_data_i;
   logic [3:0]  ram_wr_en_i;
   logic        ram_rd_en_i;
   logic [31:0] ram_rd_addr_i;
   logic [2:0]  ld_funct3_i;
   logic [31:0] ld_data_o;
   logic        ld_valid_o;
   logic        ld_misalign_o;

   modport master (
      output ram_wr_addr_i, ram_wr_data_i, ram_wr_en_i,
      output ram_rd_en_i, ram_rd_addr_i, ld_funct3_i,
      input  ld_data_o, ld_valid_o, ld_misalign_o
   );

   modport slave (
      input  ram_wr_addr_i, ram_wr_data_i, ram_wr_en_i,
      input  ram_rd_en_i, ram_rd_addr_i, ld_funct3_i,
      output ld_data_o, ld_valid_o, ld_misalign_o
   );

endinterface

// File: rtl/data_ram_ld_align.sv
// Combinational load alignment: picks the byte/halfword/word addressed by the
// byte offset, extends it per RV32I funct3 and flags misaligned accesses.
module data_ram_ld_align
   import data_ram_pkg::*;
(
   input  word_t       word_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o,
   output logic        misalign_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
      data_o     = RST_DATA;
      misalign_o = 1'b0;
      byte_sel   = word_i[offset_i];
      half_sel   = offset_i[1] ? word_i[3:2] : word_i[1:0];
      case (funct3_i)
         INST_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
         INST_LBU: data_o = {24'h0, byte_sel};
         INST_LH: begin
            if (offset_i[0]) misalign_o = 1'b1;
            else             data_o = {{16{half_sel[15]}}, half_sel};
         end
         INST_LHU: begin
            if (offset_i[0]) misalign_o = 1'b1;
            else             data_o = {16'h0, half_sel};
         end
         INST_LW: begin
            if (offset_i != 2'b00) misalign_o = 1'b1;
            else                   data_o = word_i;
         end
         default: ;  // undefined load types return zero, not flagged
      endcase
   end

endmodule

// File: rtl/data_ram.sv
// Byte-writable data memory with a registered one-cycle load path.
// Define DATA_RAM_BYPASS_EN for write-first same-word collisions; default is read-first.
module data_ram
   import data_ram_pkg::*;
#(
   parameter  int DEPTH_WORDS = DATA_RAM_DEPTH,
   localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic       clk,
   input  logic       rst,
   data_ram_if.slave  bus
);

   word_t            mem [DEPTH_WORDS];
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   word_t            rd_word;

   logic       valid_d,  valid_q;
   word_t      word_d,   word_q;
   logic [1:0] offset_d, offset_q;
   logic [2:0] funct3_d, funct3_q;

   logic [31:0] align_data;
   logic        align_misalign;
   logic        unused_addr_bits;

   assign wr_idx = bus.ram_wr_addr_i[IDX_W+1:2];
   assign rd_idx = bus.ram_rd_addr_i[IDX_W+1:2];
   assign unused_addr_bits = ^{bus.ram_wr_addr_i[31:IDX_W+2], bus.ram_wr_addr_i[1:0],
                               bus.ram_rd_addr_i[31:IDX_W+2]};

   // NOTE: the array has no reset so it can map onto block RAM; rst only gates the write.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int n = 0; n < 4; n++) begin
            if (bus.ram_wr_en_i[n]) mem[wr_idx][n] <= bus.ram_wr_data_i[8*n +: 8];
         end
      end
   end

   always_comb begin
      rd_word = mem[rd_idx];
`ifdef DATA_RAM_BYPASS_EN
      // Write-first: splice this cycle's store lanes into a same-word load.
      if (bus.ram_wr_en_i != RAM_WR_DISABLE && wr_idx == rd_idx) begin
         for (int n = 0; n < 4; n++) begin
            if (bus.ram_wr_en_i[n]) rd_word[n] = bus.ram_wr_data_i[8*n +: 8];
         end
      end
`endif
   end

   always_comb begin
      valid_d  = bus.ram_rd_en_i;
      word_d   = word_q;
      offset_d = offset_q;
      funct3_d = funct3_q;
      if (bus.ram_rd_en_i) begin
         word_d   = rd_word;
         offset_d = bus.ram_rd_addr_i[1:0];
         funct3_d = bus.ld_funct3_i;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= 1'b0;
         word_q   <= RST_DATA;
         offset_q <= 2'b00;
         funct3_q <= INST_LB;
      end else begin
         valid_q  <= valid_d;
         word_q   <= word_d;
         offset_q <= offset_d;
         funct3_q <= funct3_d;
      end
   end

   data_ram_ld_align u_ld_align (
      .word_i     (word_q),
      .offset_i   (offset_q),
      .funct3_i   (funct3_q),
      .data_o     (align_data),
      .misalign_o (align_misalign)
   );

   // Outputs are held at their reset values whenever no result is presented.
   assign bus.ld_valid_o    = valid_q;
   assign bus.ld_data_o     = valid_q ? align_data : RST_DATA;
   assign bus.ld_misalign_o = valid_q & align_misalign;

endmodule

// File: tb/tb_data_ram.sv
// Scoreboard bench for data_ram: the driver queues expected load results,
// a negedge monitor pops and compares them against each ld_valid_o pulse.
module tb_data_ram;
   import data_ram_pkg::*;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   typedef struct {
      logic [31:0] data;
      logic        mis;
      int          cyc;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];

   data_ram_if bus ();

   data_ram #(.DEPTH_WORDS(4096)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One bus cycle: drive at negedge, queue the expectation, advance to next negedge.
   task automatic drive(input logic [3:0] we, input logic [31:0] wa, input logic [31:0] wd,
                        input logic re, input logic [31:0] ra, input logic [2:0] f3,
                        input logic [31:0] exp_d, input logic exp_m, input string nm);
      exp_t e;
      bus.ram_wr_en_i   = we;
      bus.ram_wr_addr_i = wa;
      bus.ram_wr_data_i = wd;
      bus.ram_rd_en_i   = re;
      bus.ram_rd_addr_i = ra;
      bus.ld_funct3_i   = f3;
      if (re) begin
         e.data = exp_d;
         e.mis  = exp_m;
         e.cyc  = cyc + 1;
         exp_q.push_back(e);
         name_q.push_back(nm);
      end
      @(negedge clk);
   endtask

   task automatic store(input logic [3:0] we, input logic [31:0] wa, input logic [31:0] wd);
      drive(we, wa, wd, 1'b0, 32'h0, INST_LB, 32'h0, 1'b0, "");
   endtask

   task automatic load(input logic [31:0] ra, input logic [2:0] f3,
                       input logic [31:0] exp_d, input logic exp_m, input string nm);
      drive(RAM_WR_DISABLE, 32'h0, 32'h0, 1'b1, ra, f3, exp_d, exp_m, nm);
   endtask

   task automatic idle();
      drive(RAM_WR_DISABLE, 32'h0, 32'h0, 1'b0, 32'h0, INST_LB, 32'h0, 1'b0, "");
   endtask

   always @(negedge clk) begin
      if (bus.ld_valid_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", {31'h0, bus.ld_valid_o}, 32'h0);
         end else begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check({nm, "_data"}, bus.ld_data_o, e.data);
            check({nm, "_misalign"}, {31'h0, bus.ld_misalign_o}, {31'h0, e.mis});
            check({nm, "_cycle"}, 32'(cyc), 32'(e.cyc));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected earlier finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] coll_full, coll_part;
`ifdef DATA_RAM_BYPASS_EN
      coll_full = 32'h1234_5678;
      coll_part = 32'h1234_56AA;
`else
      coll_full = 32'h0000_0000;
      coll_part = 32'h1234_5678;
`endif
      rst = 1'b1;
      bus.ram_wr_en_i   = RAM_WR_DISABLE;
      bus.ram_wr_addr_i = 32'h0;
      bus.ram_wr_data_i = 32'h0;
      bus.ram_rd_en_i   = 1'b0;
      bus.ram_rd_addr_i = 32'h0;
      bus.ld_funct3_i   = INST_LB;
      repeat (3) @(negedge clk);
      check("reset_valid", {31'h0, bus.ld_valid_o}, 32'h0);
      check("reset_data", bus.ld_data_o, 32'h0);
      check("reset_misalign", {31'h0, bus.ld_misalign_o}, 32'h0);
      rst = 1'b0;
      idle();

      // Full-word store, load the very next cycle
      store(4'b1111, 32'h10, 32'hDEAD_BEEF);
      load(32'h10, INST_LW, 32'hDEAD_BEEF, 1'b0, "lw_full");

      // Byte/halfword extraction, streamed back to back
      store(4'b1111, 32'h10, 32'h80FF_7F01);
      load(32'h10, INST_LB,  32'h0000_0001, 1'b0, "lb_0");
      load(32'h11, INST_LB,  32'h0000_007F, 1'b0, "lb_1");
      load(32'h12, INST_LB,  32'hFFFF_FFFF, 1'b0, "lb_2");
      load(32'h13, INST_LB,  32'hFFFF_FF80, 1'b0, "lb_3");
      load(32'h13, INST_LBU, 32'h0000_0080, 1'b0, "lbu_3");
      load(32'h12, INST_LH,  32'hFFFF_80FF, 1'b0, "lh_2");
      load(32'h12, INST_LHU, 32'h0000_80FF, 1'b0, "lhu_2");
      load(32'h10, INST_LHU, 32'h0000_7F01, 1'b0, "lhu_0");
      load(32'h10, INST_LH,  32'h0000_7F01, 1'b0, "lh_0");

      // Partial-lane store
      store(4'b1111, 32'h10, 32'h1122_3344);
      store(4'b0100, 32'h12, 32'h00AB_0000);
      load(32'h10, INST_LW,  32'h11AB_3344, 1'b0, "lw_partial");
      load(32'h12, INST_LB,  32'hFFFF_FFAB, 1'b0, "lb_partial");

      // Misalignment and undefined funct3
      load(32'h11, INST_LW,  32'h0, 1'b1, "lw_mis_1");
      load(32'h12, INST_LW,  32'h0, 1'b1, "lw_mis_2");
      load(32'h13, INST_LH,  32'h0, 1'b1, "lh_mis_3");
      load(32'h11, INST_LHU, 32'h0, 1'b1, "lhu_mis_1");
      load(32'h12, INST_LH,  32'h0000_11AB, 1'b0, "lh_aligned_2");
      load(32'h10, 3'b011,   32'h0, 1'b0, "undef_011");
      load(32'h10, 3'b110,   32'h0, 1'b0, "undef_110");
      load(32'h11, 3'b111,   32'h0, 1'b0, "undef_111");
      load(32'h10, INST_LW,  32'h11AB_3344, 1'b0, "lw_after_mis");

      // Same-cycle collisions, aliasing and independent words
      store(4'b1111, 32'h20, 32'h0);
      drive(4'b1111, 32'h20, 32'h1234_5678, 1'b1, 32'h20, INST_LW, coll_full, 1'b0, "collide_full");
      load(32'h20, INST_LW, 32'h1234_5678, 1'b0, "after_collide");
      drive(4'b0001, 32'h20, 32'h0000_00AA, 1'b1, 32'h20, INST_LW, coll_part, 1'b0, "collide_part");
      store(4'b1111, 32'h4020, 32'hCAFE_F00D);
      load(32'h20, INST_LW, 32'hCAFE_F00D, 1'b0, "wrap_alias");
      drive(4'b1111, 32'h24, 32'h5555_AAAA, 1'b1, 32'h20, INST_LW, 32'hCAFE_F00D, 1'b0, "diff_word");
      load(32'h8024, INST_LW, 32'h5555_AAAA, 1'b0, "wrap_read");
      idle();
      idle();

      // Reset lands on the edge that samples a load and a store: both dropped
      bus.ram_wr_en_i   = 4'b1111;
      bus.ram_wr_addr_i = 32'h24;
      bus.ram_wr_data_i = 32'hBADB_AD00;
      bus.ram_rd_en_i   = 1'b1;
      bus.ram_rd_addr_i = 32'h20;
      bus.ld_funct3_i   = INST_LW;
      #2 rst = 1'b1;
      @(negedge clk);
      check("rst_no_pulse", {31'h0, bus.ld_valid_o}, 32'h0);
      idle();
      rst = 1'b0;
      idle();
      check("post_rst_valid", {31'h0, bus.ld_valid_o}, 32'h0);
      check("post_rst_data", bus.ld_data_o, 32'h0);

      // Three consecutive loads after reset
      load(32'h24, INST_LW,  32'h5555_AAAA, 1'b0, "stream_0");
      load(32'h20, INST_LW,  32'hCAFE_F00D, 1'b0, "stream_1");
      load(32'h24, INST_LBU, 32'h0000_00AA, 1'b0, "stream_2");
      repeat (3) idle();

      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
